// File: rtl/sprite_compositor.sv
// Priority compositor for sprite channels with frame-synchronous visibility mask loading.
// Define SPRITE_COLLISION_EN to build the COLL_A/COLL_B overlap detector and hit counter.
module sprite_compositor #(
    parameter int                      CHANNELS    = 8,
    parameter int                      ELEMENT     = 5,
    parameter int                      ADDR_W      = 10,
    parameter logic [2:0]              PLAY_STATE  = 3'b001,
    parameter logic [CHANNELS-1:0]     ALWAYS_MASK = {{(CHANNELS-1){1'b0}}, 1'b1},
    parameter int                      COLL_A      = 1,
    parameter int                      COLL_B      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         active,
    input  logic                         frame_start,
    input  logic [2:0]                   stateGame,
    input  logic [CHANNELS-1:0]          ch_enable,
    input  logic [CHANNELS*ELEMENT-1:0]  ch_element,
    input  logic [CHANNELS*ADDR_W-1:0]   ch_address,
    input  logic                         mask_valid,
    input  logic [CHANNELS-1:0]          mask_data,
    output logic                         mask_ready,
    output logic                         ready,
    output logic [ELEMENT-1:0]           element,
    output logic [ADDR_W-1:0]            address,
    output logic                         collision,
    output logic [7:0]                   hit_count
);

    logic [CHANNELS-1:0] r_vis_mask;
    logic [CHANNELS-1:0] r_shadow_mask;
    logic                r_mask_ready;
    logic                r_ready;
    logic [ELEMENT-1:0]  r_element;
    logic [ADDR_W-1:0]   r_address;

    logic [CHANNELS-1:0] w_elig;
    logic                w_any;
    logic [ELEMENT-1:0]  w_sel_elem;
    logic [ADDR_W-1:0]   w_sel_addr;

    assign w_elig = ch_enable & r_vis_mask &
                    (ALWAYS_MASK | {CHANNELS{stateGame == PLAY_STATE}});

    // Lowest-index eligible channel wins: scan downward so lower indices overwrite.
    always_comb begin
        w_any      = 1'b0;
        w_sel_elem = '0;
        w_sel_addr = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_sel_elem = w_elig[i] ? ch_element[i*ELEMENT +: ELEMENT] : w_sel_elem;
            w_sel_addr = w_elig[i] ? ch_address[i*ADDR_W +: ADDR_W]   : w_sel_addr;
            w_any      = w_any | w_elig[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_element <= '0;
            r_address <= '0;
        end else if (active && w_any) begin
            r_ready   <= 1'b1;
            r_element <= w_sel_elem;
            r_address <= w_sel_addr;
        end else begin
            r_ready   <= 1'b0;
            r_element <= '0;
            r_address <= '0;
        end
    end

    // mask_ready low means the shadow holds an uncommitted mask; a capture made
    // during frame_start leaves mask_ready high that cycle, so it waits a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vis_mask    <= '1;
            r_shadow_mask <= '1;
            r_mask_ready  <= 1'b1;
        end else if (mask_valid && r_mask_ready) begin
            r_shadow_mask <= mask_data;
            r_mask_ready  <= 1'b0;
        end else if (frame_start && !r_mask_ready) begin
            r_vis_mask    <= r_shadow_mask;
            r_mask_ready  <= 1'b1;
        end else begin
            r_vis_mask    <= r_vis_mask;
            r_shadow_mask <= r_shadow_mask;
            r_mask_ready  <= r_mask_ready;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic       r_pending;
    logic       r_collision;
    logic [7:0] r_hit_count;
    logic       w_overlap;

    assign w_overlap = active & w_elig[COLL_A] & w_elig[COLL_B];

    // Overlap seen in the frame_start cycle seeds the new frame's pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_collision <= 1'b0;
            r_hit_count <= 8'd0;
        end else if (frame_start) begin
            r_collision <= r_pending;
            r_pending   <= w_overlap;
            if (r_pending && (r_hit_count != 8'd255)) begin
                r_hit_count <= r_hit_count + 8'd1;
            end else begin
                r_hit_count <= r_hit_count;
            end
        end else begin
            r_pending   <= r_pending | w_overlap;
            r_collision <= r_collision;
            r_hit_count <= r_hit_count;
        end
    end

    assign collision = r_collision;
    assign hit_count = r_hit_count;
`else
    assign collision = 1'b0;
    assign hit_count = 8'd0;
`endif

    assign mask_ready = r_mask_ready;
    assign ready      = r_ready;
    assign element    = r_element;
    assign address    = r_address;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor (default parameters).
module tb_sprite_compositor;

    localparam int CH = 8;
    localparam int EL = 5;
    localparam int AW = 10;
`ifdef SPRITE_COLLISION_EN
    localparam bit COLL_ON = 1'b1;
`else
    localparam bit COLL_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            active;
    logic            frame_start;
    logic [2:0]      stateGame;
    logic [CH-1:0]   ch_enable;
    logic [CH*EL-1:0] ch_element;
    logic [CH*AW-1:0] ch_address;
    logic            mask_valid;
    logic [CH-1:0]   mask_data;
    logic            mask_ready;
    logic            ready;
    logic [EL-1:0]   element;
    logic [AW-1:0]   address;
    logic            collision;
    logic [7:0]      hit_count;

    int checks = 0;
    int errors = 0;

    sprite_compositor dut (
        .clk(clk), .reset(reset), .active(active), .frame_start(frame_start),
        .stateGame(stateGame), .ch_enable(ch_enable), .ch_element(ch_element),
        .ch_address(ch_address), .mask_valid(mask_valid), .mask_data(mask_data),
        .mask_ready(mask_ready), .ready(ready), .element(element), .address(address),
        .collision(collision), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input logic r, input logic [EL-1:0] e, input logic [AW-1:0] a);
        check({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
        check({tag, "_elem"}, {27'd0, element}, {27'd0, e});
        check({tag, "_addr"}, {22'd0, address}, {22'd0, a});
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; frame_start = 1'b0; stateGame = 3'b000;
        ch_enable = 8'h00; ch_element = '0; ch_address = '0;
        mask_valid = 1'b0; mask_data = 8'h00;
        for (int i = 0; i < CH; i++) begin
            ch_element[i*EL +: EL] = 5'(i + 8);
            ch_address[i*AW +: AW] = 10'(10'h100 + i * 17);
        end
        ch_element[2*EL +: EL] = 5'd3;   ch_address[2*AW +: AW] = 10'h055;
        ch_element[6*EL +: EL] = 5'd4;   ch_address[6*AW +: AW] = 10'h2AA;
        ch_element[0*EL +: EL] = 5'd7;   ch_address[0*AW +: AW] = 10'h100;
        ch_element[3*EL +: EL] = 5'd9;   ch_address[3*AW +: AW] = 10'h0F3;
        ch_element[1*EL +: EL] = 5'd2;   ch_address[1*AW +: AW] = 10'h011;
        ch_element[5*EL +: EL] = 5'd6;   ch_address[5*AW +: AW] = 10'h3C5;
        step(); step();
        pix("reset", 1'b0, 5'd0, 10'd0);
        check("reset_mask_ready", {31'd0, mask_ready}, 32'd1);
        check("reset_collision", {31'd0, collision}, 32'd0);
        check("reset_hits", {24'd0, hit_count}, 32'd0);

        reset = 1'b0; active = 1'b1; stateGame = 3'b001; ch_enable = 8'b0100_0100;
        step();
        pix("priority", 1'b1, 5'd3, 10'h055);

        stateGame = 3'b000; ch_enable = 8'b0000_1001;
        step();
        pix("gate_ch0", 1'b1, 5'd7, 10'h100);
        ch_enable = 8'b0000_1000;
        step();
        pix("gate_ch3_blocked", 1'b0, 5'd0, 10'd0);

        ch_enable = 8'b0000_0001; active = 1'b0;
        step();
        pix("inactive", 1'b0, 5'd0, 10'd0);

        // Mask handshake mid-frame
        active = 1'b1; stateGame = 3'b001; ch_enable = 8'b0000_1000;
        mask_valid = 1'b1; mask_data = 8'hF7;
        step();
        check("mask_ready_drop", {31'd0, mask_ready}, 32'd0);
        pix("mask_pre1", 1'b1, 5'd9, 10'h0F3);
        mask_data = 8'h00;
        step();
        check("mask_ignored_ready", {31'd0, mask_ready}, 32'd0);
        mask_valid = 1'b0;
        step();
        pix("mask_pre2", 1'b1, 5'd9, 10'h0F3);
        frame_start = 1'b1;
        step();
        pix("mask_fs_cycle", 1'b1, 5'd9, 10'h0F3);
        check("mask_ready_back", {31'd0, mask_ready}, 32'd1);
        frame_start = 1'b0;
        step();
        pix("mask_ch3_blocked", 1'b0, 5'd0, 10'd0);
        ch_enable = 8'b0000_1001;
        step();
        pix("mask_ch0_kept", 1'b1, 5'd7, 10'h100);

        // Capture coinciding with frame_start applies one frame later
        ch_enable = 8'b0000_0001; mask_valid = 1'b1; mask_data = 8'hFE; frame_start = 1'b1;
        step();
        check("coinc_ready_drop", {31'd0, mask_ready}, 32'd0);
        mask_valid = 1'b0; frame_start = 1'b0;
        step();
        pix("coinc_still_shown", 1'b1, 5'd7, 10'h100);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        pix("coinc_applied", 1'b0, 5'd0, 10'd0);
        check("coinc_ready_back", {31'd0, mask_ready}, 32'd1);
        mask_valid = 1'b1; mask_data = 8'hFF;
        step();
        mask_valid = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check("restore_coll", {31'd0, collision}, 32'd0);

        // Collision in frame N
        ch_enable = 8'b0010_0010;
        step();
        pix("coll_priority", 1'b1, 5'd2, 10'h011);
        ch_enable = 8'h00;
        step();
        frame_start = 1'b1;
        step();
        check("coll_n1", {31'd0, collision}, {31'd0, COLL_ON});
        check("hits_n1", {24'd0, hit_count}, COLL_ON ? 32'd1 : 32'd0);
        frame_start = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        check("coll_n2", {31'd0, collision}, 32'd0);
        check("hits_n2", {24'd0, hit_count}, COLL_ON ? 32'd1 : 32'd0);

        // Overlap during the frame_start cycle belongs to the new frame
        ch_enable = 8'b0010_0010;
        step();
        check("coll_fs_overlap_now", {31'd0, collision}, 32'd0);
        ch_enable = 8'h00; frame_start = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        check("coll_fs_overlap", {31'd0, collision}, {31'd0, COLL_ON});
        check("hits_fs_overlap", {24'd0, hit_count}, COLL_ON ? 32'd2 : 32'd0);

        // Saturation
        ch_enable = 8'b0010_0010;
        for (int f = 0; f < 300; f++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
        check("hits_saturated", {24'd0, hit_count}, COLL_ON ? 32'd255 : 32'd0);
        check("coll_saturated", {31'd0, collision}, {31'd0, COLL_ON});

        // Async reset mid-frame and mid-handshake
        mask_valid = 1'b1; mask_data = 8'h00;
        step();
        mask_valid = 1'b0;
        check("pre_reset_mask_ready", {31'd0, mask_ready}, 32'd0);
        pix("pre_reset", 1'b1, 5'd2, 10'h011);
        #2;
        reset = 1'b1;
        #1;
        pix("async_reset", 1'b0, 5'd0, 10'd0);
        check("async_mask_ready", {31'd0, mask_ready}, 32'd1);
        check("async_coll", {31'd0, collision}, 32'd0);
        check("async_hits", {24'd0, hit_count}, 32'd0);
        step();
        reset = 1'b0; ch_enable = 8'b0000_1000;
        step();
        pix("post_reset_mask", 1'b1, 5'd9, 10'h0F3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
